mtx_arbiter: RTL and testbench
==============================

# mtx_arbiter

Parameterised N-way matrix arbiter with least-recently-granted fairness. The block picks exactly one winner among active requesters using an N×N pairwise priority matrix. When update is enabled, it demotes the winner to lowest priority. It sits in front of any shared resource (bus, port, buffer) that needs a one-hot, zero-latency grant with fair rotation.

## Interface
- `N`, default 4: number of requesters; legal range 2..16.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rstn` in 1: synchronous, active-high reset. The port keeps the codebase name; a value of 1 resets the block on the next rising edge.
- `upd` in 1: priority-update enable. When 1, the current winner is demoted at the clock edge.
- `req` in N: request vector; bit i is requester i.
- `gnt` out N: grant vector; one-hot or zero.

## Operation
- State: priority bit `W[i][j]` for each pair i<j.
  - 1 means i beats j.
  - `W[j][i]` is implicitly `~W[i][j]`.
  - Only N(N-1)/2 flops are stored; the diagonal is unused.
- Reset value: `W[i][j]=1` for all i<j, giving strict fixed priority with requester 0 highest and N-1 lowest.
- Grant (combinational from `req` and W):
  - `gnt[i] = req[i]` AND, for every j≠i, NOT (`req[j]` AND j beats i).
  - The matrix is always a total order, so `gnt` is one-hot whenever `req≠0`.
  - `gnt` is 0 when `req=0`.
- Update: at a rising edge with `upd=1`, `rstn=0` and `gnt≠0`, for winner w:
  - every other k now beats w (row w cleared, column w set);
  - the relative order of all other pairs is unchanged.
- No update when `upd=0` or `gnt=0`. W holds.
- `gnt` is forced to 0 while `rstn=1`, regardless of `req`.

## Timing
- Grant latency: zero cycles; `gnt` follows `req` combinationally within the same cycle.
- Update latency: the new priority affects `gnt` starting the cycle after the edge that recorded the win.
- Reset: takes effect at the first rising edge with `rstn=1`. W is restored to fixed order, and `gnt` reads 0 for the whole time `rstn=1`.
- Reset mid-operation discards all history; no partial update occurs on that edge.
- Simultaneous `rstn=1` and `upd=1`: reset wins.
- Requests dropping or arriving mid-stream:
  - No handshake; `gnt` is recomputed every cycle.
  - A winner that withdraws its request before the edge is not demoted.
- A single active requester always gets the grant. It is demoted if `upd=1`, which has no effect on its own grant.
- Stable `req` with `upd=1` rotates grants round-robin among the active requesters.

## Structure
- Shared package `arb_pkg`:
  - `MAX_N` constant (16);
  - helper function `pair_idx(i,j)` mapping i<j to a triangular storage index.
- One sub-module, `mtx_arb_row`, instantiated per requester:
  - computes `gnt[i]` from `req` and the row/column priority bits;
  - computes the next-state bits for row i.
- The top level holds the triangular register, the reset logic and the generate loop.
- Elaboration assertion: `N>=2` and `N<=MAX_N`.
- Simulation assertions:
  - `$onehot0(gnt)`;
  - `gnt & ~req == 0`.

## Test plan
Scenarios 2–5 use N=3 with `upd=1` throughout.
1. Reset: hold `rstn=1` with `req=3'b111` → `gnt=000` during reset. After release, `req=111` → `gnt=001`.
2. Rotation, with `req` changing each cycle after reset → expected `gnt` per cycle:
   - `req=111, 111, 101, 101, 100, 000, 010` → `gnt=001, 010, 100, 001, 100, 000, 010`.
3. Hold, continuing from scenario 2:
   - Drop `upd` to 0 after the final `010` grant has been recorded.
   - Keep `req=010` → `gnt=010` on every cycle; priority order stays 0>2>1.
   - Then `req=111` → `gnt=001` on every cycle, with no rotation.
4. Idle: `req=000` with `upd=1` for several cycles → `gnt=000` and W unchanged. Next `req=111` grants the same index it would have before the idle period.
5. Reset mid-rotation: after grants 001 and 010, assert `rstn=1` for one cycle, then `req=111` → `gnt=001` (fixed order restored).
6. Fairness, N=4, random `req`, `upd=1`, 10k cycles:
   - `gnt` is always one-hot0 and a subset of `req`;
   - a continuously requesting index waits at most N-1 grants to other requesters.

Source files
------------

// File: rtl/mtx_arbiter_pkg.sv
// Shared definitions for the matrix arbiter: size limit and the triangular
// storage mapping for the pairwise priority bits.
package arb_pkg;

    localparam int MAX_N = 16;

    // Map an ordered pair (i, j) with i < j onto a dense index into the
    // upper-triangle storage. The mapping does not depend on N, so a pair
    // keeps the same slot whatever the arbiter width.
    function automatic int pair_idx(input int i, input int j);
        return (j * (j - 1)) / 2 + i;
    endfunction

endpackage

// File: rtl/mtx_arbiter_if.sv
// Request/grant bundle between the arbiter and the agents that use it.
interface mtx_arbiter_if #(
    parameter int N = 4
) ();

    logic         upd;
    logic [N-1:0] req;
    logic [N-1:0] gnt;

    // The requesting side drives requests and the update enable.
    modport master (
        output upd,
        output req,
        input  gnt
    );

    // The arbiter itself.
    modport slave (
        input  upd,
        input  req,
        output gnt
    );

endinterface

// File: rtl/mtx_arbiter_row.sv
// One row of the priority matrix: decides whether requester I wins and
// what requester I's priority bits become if the current grant is recorded.
module mtx_arb_row
    import arb_pkg::*;
#(
    parameter int N = 4,
    parameter int I = 0
) (
    input  logic [N-1:0] req_i,    // all request lines
    input  logic [N-1:0] beats_i,  // beats_i[j] = 1 when I beats j; bit I is 0
    input  logic [N-1:0] gnt_i,    // full raw grant vector (one-hot or zero)
    output logic         gnt_o,    // I wins this cycle
    output logic [N-1:0] nxt_o     // row I after demoting the current winner
);

    localparam logic [N-1:0] SELF = N'(1) << I;

    // I wins if it requests and no other active requester outranks it.
    assign gnt_o = req_i[I] & ~|(req_i & ~beats_i & ~SELF);

    // If I won, it drops below everybody; if some j won, I now beats j;
    // otherwise the pair keeps its order.
    assign nxt_o = gnt_i[I] ? '0 : (beats_i | gnt_i);

endmodule

// File: rtl/mtx_arbiter.sv
// N-way matrix arbiter with least-recently-granted rotation. Holds the
// upper-triangle priority bits, expands them into full rows for the row
// slices, and commits the demotion of the winner when updates are enabled.
module mtx_arbiter
    import arb_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rstn,   // active-high synchronous reset
    mtx_arbiter_if.slave arb
);

    localparam int NP = N * (N - 1) / 2;

    if (N < 2 || N > MAX_N) begin : g_bad_n
        $error("mtx_arbiter: N must be in 2..%0d", MAX_N);
    end

    logic [NP-1:0] w_q;
    logic [NP-1:0] w_d;
    logic [NP-1:0] w_upd;
    logic [N-1:0]  gnt_raw;
    logic [N-1:0]  beats          [N];
    logic [N-1:0]  row_nxt        [N];
    logic [N-1:0]  row_nxt_unused [N];   // lower-triangle duplicates, not stored

    for (genvar gi = 0; gi < N; gi++) begin : g_row
        for (genvar gj = 0; gj < N; gj++) begin : g_col
            if (gj > gi) begin : g_upper
                localparam int P = pair_idx(gi, gj);
                assign beats[gi][gj]          = w_q[P];
                assign beats[gj][gi]          = ~w_q[P];
                assign w_upd[P]               = row_nxt[gi][gj];
                assign row_nxt_unused[gi][gj] = 1'b0;
            end else begin : g_lower
                assign row_nxt_unused[gi][gj] = row_nxt[gi][gj];
                if (gj == gi) begin : g_diag
                    assign beats[gi][gi] = 1'b0;
                end
            end
        end

        mtx_arb_row #(
            .N (N),
            .I (gi)
        ) u_row (
            .req_i   (arb.req),
            .beats_i (beats[gi]),
            .gnt_i   (gnt_raw),
            .gnt_o   (gnt_raw[gi]),
            .nxt_o   (row_nxt[gi])
        );
    end

    // Commit the demoted matrix only when a grant is actually being recorded.
    always_comb begin
        w_d = w_q;
        if (arb.upd && (gnt_raw != '0)) begin
            w_d = w_upd;
        end
    end

    // Priority state; reset restores strict order 0 > 1 > ... > N-1.
    always_ff @(posedge clk) begin
        if (rstn) begin
            w_q <= '1;
        end else begin
            w_q <= w_d;
        end
    end

    assign arb.gnt = rstn ? '0 : gnt_raw;

    // Grant must be one-hot or zero and only ever go to a requester.
    always @(posedge clk) begin
        if (!rstn) begin
            assert ($onehot0(gnt_raw));
            assert ((gnt_raw & ~arb.req) == '0);
        end
    end

endmodule

// File: tb/tb_mtx_arbiter.sv
// Bench for mtx_arbiter: an ordered list of requesters (most deserving
// first) is the reference; a grant goes to the first listed requester that
// is asking, and a recorded winner moves to the back of the list.
module tb_mtx_arbiter;

    localparam int N = 4;

    logic clk = 1'b0;
    logic rstn;

    always #5 clk = ~clk;

    mtx_arbiter_if #(.N(N)) bus ();

    mtx_arbiter #(.N(N)) u_dut (
        .clk  (clk),
        .rstn (rstn),
        .arb  (bus)
    );

    int           checks   = 0;
    int           passes   = 0;
    int           ord      [N];
    int           wait_cnt [N];
    bit           model_en = 1'b0;
    bit           fair_en  = 1'b0;
    logic [N-1:0] exp_g;
    logic [N-1:0] rnd_req;

    function automatic logic [N-1:0] model_gnt(input logic [N-1:0] r);
        logic [N-1:0] g;
        g = '0;
        for (int k = 0; k < N; k++) begin
            if (r[ord[k]]) begin
                g[ord[k]] = 1'b1;
                break;
            end
        end
        return g;
    endfunction

    task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: gnt=%b expected %b at t=%0t", name, act, exp, $time);
    endtask

    // Reference state advances on each rising edge with the inputs of the cycle.
    always @(posedge clk) begin
        int p;
        int w;
        if (rstn === 1'b1) begin
            for (int k = 0; k < N; k++) ord[k] = k;
        end else if (bus.upd === 1'b1) begin
            p = -1;
            for (int k = 0; k < N; k++) begin
                if (p < 0 && bus.req[ord[k]]) p = k;
            end
            if (p >= 0) begin
                w = ord[p];
                for (int k = p; k < N - 1; k++) ord[k] = ord[k + 1];
                ord[N - 1] = w;
            end
        end
    end

    // Every cycle: compare grant with the reference; track waiting times.
    always @(negedge clk) begin
        if (model_en) begin
            exp_g = rstn ? '0 : model_gnt(bus.req);
            check("model", bus.gnt, exp_g);
            if (fair_en) begin
                for (int i = 0; i < N; i++) begin
                    if (!bus.req[i] || bus.gnt[i]) begin
                        wait_cnt[i] = 0;
                    end else if (bus.gnt != '0) begin
                        wait_cnt[i]++;
                        checks++;
                        if (wait_cnt[i] <= N - 1) passes++;
                        else $display("FAIL fairness: requester %0d waited %0d grants, limit %0d", i, wait_cnt[i], N - 1);
                    end
                end
            end
        end
    end

    task automatic drive(input logic rst, input logic up, input logic [N-1:0] r);
        @(posedge clk);
        #1;
        rstn    = rst;
        bus.upd = up;
        bus.req = r;
    endtask

    task automatic step(input logic rst, input logic up, input logic [N-1:0] r,
                        input logic [N-1:0] exp, input string name);
        drive(rst, up, r);
        @(negedge clk);
        check(name, bus.gnt, exp);
    endtask

    initial begin
        rstn    = 1'b1;
        bus.upd = 1'b0;
        bus.req = '0;
        for (int k = 0; k < N; k++) begin
            ord[k]      = k;
            wait_cnt[k] = 0;
        end
        repeat (2) @(posedge clk);
        model_en = 1'b1;

        // Requester 3 stays idle in the directed part; it never wins, so the
        // relative order of 0..2 behaves exactly as a 3-way arbiter.
        repeat (3) step(1'b1, 1'b1, 4'b0111, 4'b0000, "reset_hold");

        step(1'b0, 1'b1, 4'b0111, 4'b0001, "rot0");
        step(1'b0, 1'b1, 4'b0111, 4'b0010, "rot1");
        step(1'b0, 1'b1, 4'b0101, 4'b0100, "rot2");
        step(1'b0, 1'b1, 4'b0101, 4'b0001, "rot3");
        step(1'b0, 1'b1, 4'b0100, 4'b0100, "rot4");
        step(1'b0, 1'b1, 4'b0000, 4'b0000, "rot5");
        step(1'b0, 1'b1, 4'b0010, 4'b0010, "rot6");

        repeat (3) step(1'b0, 1'b0, 4'b0010, 4'b0010, "hold_single");
        repeat (3) step(1'b0, 1'b0, 4'b0111, 4'b0001, "hold_all");

        repeat (4) step(1'b0, 1'b1, 4'b0000, 4'b0000, "idle");
        step(1'b0, 1'b1, 4'b0111, 4'b0001, "after_idle");
        step(1'b0, 1'b1, 4'b0111, 4'b0100, "after_idle_rot");

        step(1'b1, 1'b1, 4'b0111, 4'b0000, "rst");
        step(1'b0, 1'b1, 4'b0111, 4'b0001, "pre_mid0");
        step(1'b0, 1'b1, 4'b0111, 4'b0010, "pre_mid1");
        step(1'b1, 1'b1, 4'b0111, 4'b0000, "mid_rst");
        step(1'b0, 1'b1, 4'b0111, 4'b0001, "mid_rst_fixed");

        // Lone requester keeps its grant while being demoted, then full rotation.
        repeat (2) step(1'b0, 1'b1, 4'b1000, 4'b1000, "single");
        step(1'b0, 1'b1, 4'b1111, 4'b0010, "full0");
        step(1'b0, 1'b1, 4'b1111, 4'b0100, "full1");
        step(1'b0, 1'b1, 4'b1111, 4'b0001, "full2");
        step(1'b0, 1'b1, 4'b1111, 4'b1000, "full3");

        // Random requests with updates always on: fairness bound tracked.
        rnd_req = '0;
        fair_en = 1'b1;
        repeat (10000) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 3) == 0) rnd_req[i] = ~rnd_req[i];
            end
            drive(1'b0, 1'b1, rnd_req);
        end
        @(negedge clk);
        fair_en = 1'b0;

        // Random requests, random update enable and occasional resets.
        repeat (3000) begin
            drive(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0),
                  N'($urandom_range(0, (1 << N) - 1)));
        end
        @(negedge clk);
        model_en = 1'b0;

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
